// File: rtl/iir_biquad_mc_if.sv
// Sample, control and coefficient-load bundle for the multi-channel biquad.
interface iir_biquad_mc_if #(
  parameter int DATA_W   = 6,
  parameter int COEF_W   = 14,
  parameter int CHANNELS = 2
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                     in_valid;
  logic [CH_W-1:0]          in_ch;
  logic signed [DATA_W-1:0] in_data;
  logic                     bypass;
  logic                     clear;
  logic                     coef_wr;
  logic [2:0]               coef_sel;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_commit;

  logic                     out_valid;
  logic [CH_W-1:0]          out_ch;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_sat;
  logic                     coef_pending;

  modport master (
    output in_valid, in_ch, in_data, bypass, clear,
    output coef_wr, coef_sel, coef_data, coef_commit,
    input  out_valid, out_ch, out_data, out_sat, coef_pending
  );

  modport slave (
    input  in_valid, in_ch, in_data, bypass, clear,
    input  coef_wr, coef_sel, coef_data, coef_commit,
    output out_valid, out_ch, out_data, out_sat, coef_pending
  );
endinterface

// File: rtl/iir_biquad_mc.sv
// Time-multiplexed transposed-form biquad shared by CHANNELS filter states,
// with a shadow/active coefficient pair and rounded, saturated output.
//
// Coefficient commit state:
//   state   | meaning
//   IDLE    | active set in use, no copy requested
//   PEND    | copy requested; waits for an empty pipeline with no new input
module iir_biquad_mc #(
  parameter int DATA_W   = 6,
  parameter int GUARD_W  = 3,
  parameter int COEF_W   = 14,
  parameter int FRAC     = 10,
  parameter int CHANNELS = 2
) (
  input logic            clk,
  input logic            rst_n,
  iir_biquad_mc_if.slave bus
);
  localparam int INT_W  = DATA_W + GUARD_W + 6;
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NST    = 1 << CH_W;
  localparam int PROD_W = INT_W + COEF_W + 1;

  localparam logic [CH_W:0]          C_NCH  = (CH_W+1)'(CHANNELS);
  localparam logic signed [INT_W:0]  C_RND  = (INT_W+1)'(1 << (GUARD_W-1));
  localparam logic signed [INT_W:0]  C_OMAX = (INT_W+1)'((1 << (DATA_W-1)) - 1);
  localparam logic signed [INT_W:0]  C_OMIN = (INT_W+1)'(-(1 << (DATA_W-1)));
  localparam logic signed [DATA_W-1:0] D_MAX = DATA_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [DATA_W-1:0] D_MIN = DATA_W'(-(1 << (DATA_W-1)));
  localparam logic signed [COEF_W-1:0] C_ONE = COEF_W'(1 << FRAC);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  // Full-precision product; operands sign-extended before the multiply.
  function automatic logic signed [PROD_W-1:0] mul(
    input logic signed [COEF_W-1:0] c,
    input logic signed [INT_W-1:0]  v
  );
    mul = PROD_W'(c) * PROD_W'(v);
  endfunction

  // Floor back to state precision; upper bits wrap.
  function automatic logic signed [INT_W-1:0] scale(input logic signed [PROD_W-1:0] p);
    scale = INT_W'(p >>> FRAC);
  endfunction

  // coefficients: index 0=b0 1=b1 2=b2 3=a1 4=a2
  logic signed [COEF_W-1:0] r_sh  [5];
  logic signed [COEF_W-1:0] r_act [5];
  logic [0:0]               r_cst;

  logic signed [INT_W-1:0] r_r0 [NST];
  logic signed [INT_W-1:0] r_r1 [NST];
  logic signed [INT_W-1:0] r_l0 [NST];
  logic signed [INT_W-1:0] r_l1 [NST];

  logic                     r_s0_v, r_s0_byp;
  logic [CH_W-1:0]          r_s0_ch;
  logic signed [DATA_W-1:0] r_s0_d;

  logic                     r_s1_v, r_s1_byp;
  logic [CH_W-1:0]          r_s1_ch;
  logic signed [DATA_W-1:0] r_s1_d;
  logic signed [INT_W-1:0]  r_s1_vv;

  logic                     r_s2_v, r_s2_byp;
  logic [CH_W-1:0]          r_s2_ch;
  logic signed [DATA_W-1:0] r_s2_d;
  logic signed [INT_W-1:0]  r_s2_y;

  logic                     r_out_v, r_out_sat;
  logic [CH_W-1:0]          r_out_ch;
  logic signed [DATA_W-1:0] r_out_d;

  logic                    w_acc, w_idle;
  logic signed [INT_W-1:0] w_x, w_r0_rd, w_r1_rd, w_v;
  logic signed [INT_W-1:0] w_r0_nx, w_r1_nx;
  logic signed [INT_W-1:0] w_l0_rd, w_l1_rd, w_y, w_l0_nx, w_l1_nx;
  logic signed [INT_W:0]   w_y_ext, w_o;
  logic                    w_hi, w_lo;

  assign w_acc  = bus.in_valid && ({1'b0, bus.in_ch} < C_NCH);
  assign w_idle = !r_s0_v && !r_s1_v && !r_s2_v && !bus.in_valid;

  // S1 datapath: the sample entering S1 alongside a clear sees zero state.
  assign w_x     = {{(INT_W-DATA_W){r_s0_d[DATA_W-1]}}, r_s0_d} <<< GUARD_W;
  assign w_r0_rd = bus.clear ? '0 : r_r0[r_s0_ch];
  assign w_r1_rd = bus.clear ? '0 : r_r1[r_s0_ch];
  assign w_v     = w_x + w_r0_rd;
  assign w_r0_nx = scale(-mul(r_act[3], w_v)) + w_r1_rd;
  assign w_r1_nx = scale(-mul(r_act[4], w_v));

  // S2 datapath: numerator taps on the v captured in S1.
  assign w_l0_rd = r_l0[r_s1_ch];
  assign w_l1_rd = r_l1[r_s1_ch];
  assign w_y     = scale(mul(r_act[0], r_s1_vv)) + w_l0_rd;
  assign w_l0_nx = scale(mul(r_act[1], r_s1_vv)) + w_l1_rd;
  assign w_l1_nx = scale(mul(r_act[2], r_s1_vv));

  // Output rounding (half up, then floor) and clip detection.
  assign w_y_ext = {r_s2_y[INT_W-1], r_s2_y};
  assign w_o     = (w_y_ext + C_RND) >>> GUARD_W;
  assign w_hi    = w_o > C_OMAX;
  assign w_lo    = w_o < C_OMIN;

  // Shadow coefficient writes; selects 5-7 are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh[0] <= C_ONE;
      for (int k = 1; k < 5; k++) r_sh[k] <= '0;
    end else if (bus.coef_wr) begin
      case (bus.coef_sel)
        3'd0:    r_sh[0] <= bus.coef_data;
        3'd1:    r_sh[1] <= bus.coef_data;
        3'd2:    r_sh[2] <= bus.coef_data;
        3'd3:    r_sh[3] <= bus.coef_data;
        3'd4:    r_sh[4] <= bus.coef_data;
        default: ;
      endcase
    end
  end

  // Commit control: copy shadow to active only when nothing is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cst    <= ST_IDLE;
      r_act[0] <= C_ONE;
      for (int k = 1; k < 5; k++) r_act[k] <= '0;
    end else begin
      case (r_cst)
        ST_IDLE: if (bus.coef_commit) r_cst <= ST_PEND;
        ST_PEND: if (w_idle) begin
          r_cst <= ST_IDLE;
          for (int k = 0; k < 5; k++) r_act[k] <= r_sh[k];
        end
        default: r_cst <= ST_IDLE;
      endcase
    end
  end

  assign bus.coef_pending = (r_cst == ST_PEND);

  // S0: capture accepted samples; out-of-range channels are dropped here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0_v   <= 1'b0;
      r_s0_byp <= 1'b0;
      r_s0_ch  <= '0;
      r_s0_d   <= '0;
    end else begin
      r_s0_v   <= w_acc;
      r_s0_byp <= bus.bypass;
      r_s0_ch  <= bus.in_ch;
      r_s0_d   <= bus.in_data;
    end
  end

  // S1 state write-back (denominator side).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NST; k++) begin
        r_r0[k] <= '0;
        r_r1[k] <= '0;
      end
    end else if (bus.clear) begin
      for (int k = 0; k < NST; k++) begin
        r_r0[k] <= '0;
        r_r1[k] <= '0;
      end
    end else if (r_s0_v && !r_s0_byp) begin
      r_r0[r_s0_ch] <= w_r0_nx;
      r_r1[r_s0_ch] <= w_r1_nx;
    end
  end

  // S1 pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v   <= 1'b0;
      r_s1_byp <= 1'b0;
      r_s1_ch  <= '0;
      r_s1_d   <= '0;
      r_s1_vv  <= '0;
    end else begin
      r_s1_v   <= r_s0_v;
      r_s1_byp <= r_s0_byp;
      r_s1_ch  <= r_s0_ch;
      r_s1_d   <= r_s0_d;
      r_s1_vv  <= w_v;
    end
  end

  // S2 state write-back (numerator side).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NST; k++) begin
        r_l0[k] <= '0;
        r_l1[k] <= '0;
      end
    end else if (bus.clear) begin
      for (int k = 0; k < NST; k++) begin
        r_l0[k] <= '0;
        r_l1[k] <= '0;
      end
    end else if (r_s1_v && !r_s1_byp) begin
      r_l0[r_s1_ch] <= w_l0_nx;
      r_l1[r_s1_ch] <= w_l1_nx;
    end
  end

  // S2 pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v   <= 1'b0;
      r_s2_byp <= 1'b0;
      r_s2_ch  <= '0;
      r_s2_d   <= '0;
      r_s2_y   <= '0;
    end else begin
      r_s2_v   <= r_s1_v;
      r_s2_byp <= r_s1_byp;
      r_s2_ch  <= r_s1_ch;
      r_s2_d   <= r_s1_d;
      r_s2_y   <= w_y;
    end
  end

  // S3 output register; data and flag hold between valid samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_v   <= 1'b0;
      r_out_ch  <= '0;
      r_out_d   <= '0;
      r_out_sat <= 1'b0;
    end else begin
      r_out_v <= r_s2_v;
      if (r_s2_v) begin
        r_out_ch <= r_s2_ch;
        if (r_s2_byp) begin
          r_out_d   <= r_s2_d;
          r_out_sat <= 1'b0;
        end else if (w_hi) begin
          r_out_d   <= D_MAX;
          r_out_sat <= 1'b1;
        end else if (w_lo) begin
          r_out_d   <= D_MIN;
          r_out_sat <= 1'b1;
        end else begin
          r_out_d   <= w_o[DATA_W-1:0];
          r_out_sat <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = r_out_v;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_data  = r_out_d;
  assign bus.out_sat   = r_out_sat;
endmodule

// File: tb/tb_iir_biquad_mc.sv
// Directed bench for iir_biquad_mc: vector table per scenario plus
// hand sequences for latency, commit timing and mid-stream reset.
module tb_iir_biquad_mc;
  localparam int DATA_W = 6;
  localparam int COEF_W = 14;
  localparam int CHN    = 3;
  localparam int CHW    = 2;
  localparam int NV     = 29;

  typedef struct {
    int grp; int ch; int data; bit byp; bit ev; int ed; bit es;
  } vec_t;
  typedef struct { int ch; int d; bit s; } obs_t;

  logic clk;
  logic rst_n;
  vec_t vecs [NV];
  obs_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  iir_biquad_mc_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .CHANNELS(CHN)) bus ();

  iir_biquad_mc #(.DATA_W(DATA_W), .GUARD_W(3), .COEF_W(COEF_W), .FRAC(10),
                  .CHANNELS(CHN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.out_valid) q.push_back('{int'(bus.out_ch), int'(bus.out_data), bus.out_sat});

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input int sel, input int val);
    bus.coef_wr   = 1'b1;
    bus.coef_sel  = 3'(sel);
    bus.coef_data = COEF_W'(val);
    tick();
    bus.coef_wr = 1'b0;
  endtask

  task automatic load_set(input int b0, input int b1, input int b2, input int a1, input int a2);
    wr(0, b0); wr(1, b1); wr(2, b2); wr(3, a1); wr(4, a2);
    bus.coef_commit = 1'b1;
    tick();
    bus.coef_commit = 1'b0;
    chk("pending after commit", int'(bus.coef_pending), 1);
    for (int i = 0; i < 20 && bus.coef_pending; i++) tick();
    chk("commit applied when idle", int'(bus.coef_pending), 0);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic drive(input int ch, input int data, input bit byp);
    bus.in_valid = 1'b1;
    bus.in_ch    = CHW'(ch);
    bus.in_data  = DATA_W'(data);
    bus.bypass   = byp;
  endtask

  task automatic run_group(input int g, input int gap);
    int k, nexp;
    q.delete();
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].grp == g) begin
        drive(vecs[i].ch, vecs[i].data, vecs[i].byp);
        tick();
        bus.in_valid = 1'b0;
        bus.bypass   = 1'b0;
        repeat (gap - 1) tick();
      end
    end
    repeat (6) tick();
    k = 0;
    nexp = 0;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].grp == g && vecs[i].ev) begin
        nexp++;
        if (k < q.size()) begin
          chk($sformatf("g%0d gap%0d v%0d data", g, gap, i), q[k].d, vecs[i].ed);
          chk($sformatf("g%0d gap%0d v%0d sat", g, gap, i), int'(q[k].s), int'(vecs[i].es));
          chk($sformatf("g%0d gap%0d v%0d ch", g, gap, i), q[k].ch, vecs[i].ch);
        end
        k++;
      end
    end
    chk($sformatf("g%0d gap%0d output count", g, gap), q.size(), nexp);
  endtask

  initial begin
    // grp, ch, data, byp, ev, exp_data, exp_sat
    vecs[0]  = '{0, 0,   5, 0, 1,   5, 0};
    vecs[1]  = '{0, 0,  -7, 0, 1,  -7, 0};
    vecs[2]  = '{0, 0, -32, 0, 1, -32, 0};
    vecs[3]  = '{0, 0,  31, 0, 1,  31, 0};
    vecs[4]  = '{1, 0,  16, 0, 1,   4, 0};
    vecs[5]  = '{1, 0,   0, 0, 1,   8, 0};
    vecs[6]  = '{1, 0,   0, 0, 1,   4, 0};
    vecs[7]  = '{1, 0,   0, 0, 1,   0, 0};
    vecs[8]  = '{2, 0,  16, 0, 1,  16, 0};
    vecs[9]  = '{2, 1,   0, 0, 1,   0, 0};
    vecs[10] = '{2, 0,   0, 0, 1,   8, 0};
    vecs[11] = '{2, 1,   0, 0, 1,   0, 0};
    vecs[12] = '{2, 0,   0, 0, 1,   4, 0};
    vecs[13] = '{2, 1,   0, 0, 1,   0, 0};
    vecs[14] = '{2, 0,   0, 0, 1,   2, 0};
    vecs[15] = '{2, 1,   0, 0, 1,   0, 0};
    vecs[16] = '{2, 0,   0, 0, 1,   1, 0};
    vecs[17] = '{3, 0,  31, 0, 1,  31, 1};
    vecs[18] = '{3, 0, -32, 0, 1, -32, 1};
    vecs[19] = '{3, 0,   3, 0, 1,   6, 0};
    vecs[20] = '{3, 0,  31, 1, 1,  31, 0};
    vecs[21] = '{3, 0,   3, 0, 1,   6, 0};
    vecs[22] = '{4, 0,  16, 0, 1,  16, 0};
    vecs[23] = '{4, 0,   8, 0, 1,  16, 0};
    vecs[24] = '{4, 0,   0, 0, 1,   8, 0};
    vecs[25] = '{4, 0,  -8, 0, 1,  -4, 0};
    vecs[26] = '{4, 3,   5, 0, 0,   0, 0};
    vecs[27] = '{5, 1,   8, 0, 1,   4, 0};
    vecs[28] = '{6, 0,  -5, 0, 1,  -5, 0};

    bus.in_valid = 1'b0; bus.in_ch = '0; bus.in_data = '0; bus.bypass = 1'b0;
    bus.clear = 1'b0; bus.coef_wr = 1'b0; bus.coef_sel = '0; bus.coef_data = '0;
    bus.coef_commit = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset out_data", int'(bus.out_data), 0);
    chk("reset out_sat", int'(bus.out_sat), 0);
    chk("reset out_ch", int'(bus.out_ch), 0);
    chk("reset coef_pending", int'(bus.coef_pending), 0);
    rst_n = 1'b1;
    tick();

    // Latency: sampled at edge n, out_valid after edge n+3.
    drive(1, 9, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick(); chk("latency n+1 out_valid", int'(bus.out_valid), 0);
    tick(); chk("latency n+2 out_valid", int'(bus.out_valid), 0);
    tick(); chk("latency n+3 out_valid", int'(bus.out_valid), 1);
    chk("latency n+3 out_data", int'(bus.out_data), 9);
    chk("latency n+3 out_ch", int'(bus.out_ch), 1);
    tick(); chk("latency n+4 out_valid", int'(bus.out_valid), 0);

    run_group(0, 1);

    load_set(256, 512, 256, 0, 0);
    run_group(1, 1);

    load_set(1024, 0, 0, -512, 0);
    run_group(2, 1);

    load_set(2048, 0, 0, 0, 0);
    do_clear();
    run_group(3, 1);

    load_set(1024, 0, 0, -512, 0);
    do_clear();
    run_group(4, 1);
    do_clear();
    run_group(4, 4);

    // Commit during a continuous stream: old set stays in use until a bubble.
    wr(0, 512);
    wr(3, 0);
    chk("shadow write leaves pending clear", int'(bus.coef_pending), 0);
    do_clear();
    q.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1, 8, 1'b0);
      bus.coef_commit = (i == 2 || i == 5);
      tick();
      if (i >= 2) chk($sformatf("stream pending cycle %0d", i), int'(bus.coef_pending), 1);
    end
    bus.in_valid = 1'b0;
    bus.coef_commit = 1'b0;
    repeat (3) tick();
    chk("pending before bubble completes", int'(bus.coef_pending), 1);
    tick();
    chk("pending cleared at first bubble", int'(bus.coef_pending), 0);
    repeat (3) tick();
    begin
      int exp_s [8];
      exp_s = '{8, 12, 14, 15, 16, 16, 16, 16};
      chk("stream output count", q.size(), 8);
      for (int i = 0; i < 8 && i < q.size(); i++)
        chk($sformatf("stream old-set out %0d", i), q[i].d, exp_s[i]);
    end
    do_clear();
    run_group(5, 1);

    // Reset while a sample is in flight: nothing emerges afterwards.
    q.delete();
    drive(0, 7, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("no output after mid-flight reset", q.size(), 0);
    chk("pending after reset", int'(bus.coef_pending), 0);
    run_group(6, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
